spi_slave_regfile: RTL
======================

Name: spi_slave_regfile

Overview:
- SPI responder (slave) for the 32-bit, CDCE62005-style word protocol driven by the board's SPI master on SPI_SCLK/SPI_MOSI/SPI_MISO and one chip-select line.
- Holds a small register file written over SPI and reads it back through the device's read-command sequence.
- Exposes every write to the fabric as a strobe and provides a fabric-side read port.
- Serves as the slave-side model for verifying the SPI master, and as a real slave for expansion boards.

Parameters:
- NUM_REGS, 9: implemented registers, addresses 0..NUM_REGS-1; maximum 14.
- LSB_FIRST, 1: 1 = shift LSB first (CDCE62005 order); 0 = MSB first.
- RD_CMD_ADDR, 14: 4-bit address code that selects the read-command frame.

Ports:
- BOARD_CLOCK  in  1  system clock; must be at least 4x the SCLK frequency.
- RST  in  1  asynchronous, active-low reset.
- SPI_SCLK  in  1  SPI clock from the master; mode 0 (CPOL=0, CPHA=0); asynchronous to BOARD_CLOCK.
- SPI_MOSI  in  1  master-out data.
- SPI_CS_N  in  1  chip select, active low.
- SPI_MISO  out  1  slave-out data.
- SPI_MISO_OE  out  1  1 while the frame is active (synced CS_N low); pad tristate enable.
- WR_STB_O  out  1  one-cycle pulse on each committed register write.
- WR_ADDR_O  out  4  address of the committed write.
- WR_DATA_O  out  28  data of the committed write.
- REG_RADDR_I  in  4  fabric read address.
- REG_RDATA_O  out  28  combinational read of regs[REG_RADDR_I]; 0 if the address is >= NUM_REGS.
- FRAME_ERR_O  out  1  one-cycle pulse when a frame ends with a bit count other than 32.

Behaviour:
- Reset (RST low, asynchronous):
  - All regs = 0; state IDLE; read-pending = 0; rd_ptr = 0; shift register = 0; bit count = 0.
  - SPI_MISO = 0, SPI_MISO_OE = 0, WR_STB_O = 0, FRAME_ERR_O = 0.
  - Synchronizers are cleared to SCLK = 0 and CS_N = 1.
  - Reset mid-frame abandons the frame with no commit and no error pulse.
- Input sync: SCLK, MOSI and CS_N each pass through two flops, plus a third flop for edge detection. This gives sclk_rise, sclk_fall, cs_fall and cs_rise as single-cycle pulses.
- Frame format: word[3:0] = address, word[31:4] = data.
- State IDLE:
  - On cs_fall: go to SHIFT, bit count = 0, SPI_MISO_OE = 1.
  - The TX shift register loads {regs[rd_ptr], rd_ptr} if read-pending is set, else 0.
  - If rd_ptr >= NUM_REGS, the data field loads 0.
  - The first TX bit appears on SPI_MISO in the same cycle as the load.
- State SHIFT:
  - On sclk_rise: shift the synced MOSI into the RX register. Bit count increments and saturates at 33.
  - On sclk_fall: advance the TX register and drive the next bit onto SPI_MISO.
  - Shift direction for both registers is set by LSB_FIRST.
  - On cs_rise: go to COMMIT. SPI_MISO_OE = 0 and SPI_MISO = 0 in the next cycle.
  - If cs_rise and sclk_rise occur in the same cycle, the sample is taken first, then the frame ends.
- State COMMIT (exactly one cycle), then IDLE. Read-pending is cleared in this cycle whether or not the frame was valid. Then:
  - count != 32: pulse FRAME_ERR_O; no register change.
  - count == 32 and addr == RD_CMD_ADDR: rd_ptr = word[7:4]; read-pending = 1; no WR_STB_O.
  - count == 32 and addr < NUM_REGS: regs[addr] = word[31:4]; WR_STB_O pulses with addr and data.
  - Any other address: ignored silently.
- Latency: WR_STB_O asserts 4 BOARD_CLOCK cycles after SPI_CS_N rises at the pin (2 sync + 1 edge + 1 COMMIT).
- A cs_fall while in COMMIT is impossible at the 4x clock ratio. The minimum CS_N high time is 4 BOARD_CLOCK cycles.
- WR_ADDR_O and WR_DATA_O hold their last committed values between strobes.

Decomposition:
- Shared package spi_pkg:
  - Constants: SPI_WORD_BITS = 32, SPI_ADDR_BITS = 4, SPI_DATA_BITS = 28, default RD_CMD_ADDR = 14.
  - State encoding: IDLE, SHIFT, COMMIT.
  - The SPI master uses the same package.
- One sub-module, spi_sync_edge: 2-flop synchronizer plus edge detector, reset value set by parameter. Instantiated for SCLK (reset 0) and CS_N (reset 1); MOSI uses the synchronizer only.

Test Plan:
- Write frame, LSB_FIRST = 1, word 0x1234_5673 (addr 3, data 0x123_4567) -> one WR_STB_O pulse with addr 3, data 0x1234567; REG_RDATA_O at address 3 = 0x1234567; FRAME_ERR_O stays 0.
- Read-back: write 0xABCDEF1 to address 5, send read command word 0x0000_005E, then a dummy frame 0x0 -> MISO shifts out 0xABCDEF15 LSB first, and the dummy frame causes no write.
- Short frame of 31 SCLKs, then a 33-SCLK frame, each with address 2 -> FRAME_ERR_O pulses twice; register 2 unchanged; no WR_STB_O.
- Write to address 12 with NUM_REGS = 9, then a read command with rd_ptr 12 -> no strobe on the write, no error, and the next frame returns 0x0000000C.
- RST asserted at bit 17 of a write frame, released, then a full valid frame -> first frame discarded; all regs 0 after reset; second frame commits normally; MISO_OE = 0 during reset.
- LSB_FIRST = 0, SCLK at BOARD_CLOCK/4 with random CS-to-SCLK skew -> writes still commit correctly, and read-back matches in MSB-first order.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the 32-bit SPI word protocol (address nibble + 28-bit data).
// Used by both the SPI master and the register-file slave.
package spi_pkg;

    localparam int SPI_WORD_BITS = 32;
    localparam int SPI_ADDR_BITS = 4;
    localparam int SPI_DATA_BITS = 28;
    localparam logic [SPI_ADDR_BITS-1:0] SPI_RD_CMD_ADDR = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } spi_state_e;

    function automatic logic [SPI_WORD_BITS-1:0] spi_word(
        input logic [SPI_DATA_BITS-1:0] data,
        input logic [SPI_ADDR_BITS-1:0] addr
    );
        return {data, addr};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection.
// RST_VAL is the idle level of the line so reset never fabricates an edge.
module spi_sync_edge #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= {3{RST_VAL}};
        else        sr <= {sr[1:0], d};
    end

    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a small register file, read-command readback over MISO,
// a fabric write strobe and a combinational fabric read port.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int                        NUM_REGS    = 9,
    parameter bit                        LSB_FIRST   = 1'b1,
    parameter logic [SPI_ADDR_BITS-1:0]  RD_CMD_ADDR = SPI_RD_CMD_ADDR
) (
    input  logic                      BOARD_CLOCK,
    input  logic                      RST,
    input  logic                      SPI_SCLK,
    input  logic                      SPI_MOSI,
    input  logic                      SPI_CS_N,
    output logic                      SPI_MISO,
    output logic                      SPI_MISO_OE,
    output logic                      WR_STB_O,
    output logic [SPI_ADDR_BITS-1:0]  WR_ADDR_O,
    output logic [SPI_DATA_BITS-1:0]  WR_DATA_O,
    input  logic [SPI_ADDR_BITS-1:0]  REG_RADDR_I,
    output logic [SPI_DATA_BITS-1:0]  REG_RDATA_O,
    output logic                      FRAME_ERR_O
);

    localparam logic [4:0] NREGS   = 5'(NUM_REGS);
    localparam logic [5:0] CNT_SAT = 6'd33;
    localparam logic [5:0] CNT_OK  = 6'd32;

    function automatic logic in_range(input logic [SPI_ADDR_BITS-1:0] a);
        return {1'b0, a} < NREGS;
    endfunction

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_s1, mosi_s;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk   (BOARD_CLOCK),
        .rst_n (RST),
        .d     (SPI_SCLK),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (BOARD_CLOCK),
        .rst_n (RST),
        .d     (SPI_CS_N),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI has the same two-flop depth as SCLK so it lines up with sclk_rise.
    always_ff @(posedge BOARD_CLOCK or negedge RST) begin
        if (!RST) begin
            mosi_s1 <= 1'b0;
            mosi_s  <= 1'b0;
        end else begin
            mosi_s1 <= SPI_MOSI;
            mosi_s  <= mosi_s1;
        end
    end

    spi_state_e                  state;
    logic [SPI_WORD_BITS-1:0]    rx_sr, tx_sr, tx_load, rx_shift, tx_shift;
    logic [5:0]                  bit_cnt;
    logic                        rd_pend;
    logic [SPI_ADDR_BITS-1:0]    rd_ptr;
    logic [SPI_DATA_BITS-1:0]    regs [NUM_REGS];
    logic                        tx_first_bit, tx_next_bit;
    logic [SPI_ADDR_BITS-1:0]    rx_addr;
    logic [SPI_DATA_BITS-1:0]    rx_data;

    always_comb begin
        tx_load = '0;
        if (rd_pend) tx_load = spi_word(in_range(rd_ptr) ? regs[rd_ptr] : '0, rd_ptr);
    end

    assign rx_shift     = LSB_FIRST ? {mosi_s, rx_sr[SPI_WORD_BITS-1:1]} : {rx_sr[SPI_WORD_BITS-2:0], mosi_s};
    assign tx_shift     = LSB_FIRST ? {1'b0, tx_sr[SPI_WORD_BITS-1:1]} : {tx_sr[SPI_WORD_BITS-2:0], 1'b0};
    assign tx_next_bit  = LSB_FIRST ? tx_sr[1] : tx_sr[SPI_WORD_BITS-2];
    assign tx_first_bit = LSB_FIRST ? tx_load[0] : tx_load[SPI_WORD_BITS-1];
    assign rx_addr      = rx_sr[SPI_ADDR_BITS-1:0];
    assign rx_data      = rx_sr[SPI_WORD_BITS-1:SPI_ADDR_BITS];

    assign REG_RDATA_O  = in_range(REG_RADDR_I) ? regs[REG_RADDR_I] : '0;

    always_ff @(posedge BOARD_CLOCK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            rx_sr       <= '0;
            tx_sr       <= '0;
            bit_cnt     <= '0;
            rd_pend     <= 1'b0;
            rd_ptr      <= '0;
            SPI_MISO    <= 1'b0;
            SPI_MISO_OE <= 1'b0;
            WR_STB_O    <= 1'b0;
            WR_ADDR_O   <= '0;
            WR_DATA_O   <= '0;
            FRAME_ERR_O <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            WR_STB_O    <= 1'b0;
            FRAME_ERR_O <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state       <= ST_SHIFT;
                        bit_cnt     <= '0;
                        SPI_MISO_OE <= 1'b1;
                        tx_sr       <= tx_load;
                        SPI_MISO    <= tx_first_bit;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_sr <= rx_shift;
                        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 6'd1;
                    end
                    if (sclk_fall) begin
                        tx_sr    <= tx_shift;
                        SPI_MISO <= tx_next_bit;
                    end
                    // Ordered last so a coincident sample still lands before the frame closes.
                    if (cs_rise) begin
                        state       <= ST_COMMIT;
                        SPI_MISO_OE <= 1'b0;
                        SPI_MISO    <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    state   <= ST_IDLE;
                    rd_pend <= 1'b0;
                    if (bit_cnt != CNT_OK) begin
                        FRAME_ERR_O <= 1'b1;
                    end else if (rx_addr == RD_CMD_ADDR) begin
                        rd_ptr  <= rx_sr[7:4];
                        rd_pend <= 1'b1;
                    end else if (in_range(rx_addr)) begin
                        regs[rx_addr] <= rx_data;
                        WR_STB_O      <= 1'b1;
                        WR_ADDR_O     <= rx_addr;
                        WR_DATA_O     <= rx_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
